// File: rtl/hub75_pkg.sv
// Shared types and constants for the HUB75 row receiver.
// Optional on-time counter is enabled with macro HUB75_RX_OE_CNT_EN.
package hub75_pkg;

    localparam int PIX_W    = 3;   // {R,G,B} per half-panel pixel
    localparam int ADDR_W   = 4;   // {RD,RC,RB,RA}
    localparam int DEF_COLS = 32;  // default columns shifted per row

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,  // no shift clock seen since the last commit
        ST_SHIFT  = 2'd1,  // at least one pixel shifted into the current row
        ST_COMMIT = 2'd2   // single cycle: copy shift registers to the read port
    } state_e;

endpackage

// File: rtl/hub75_receiver_if.sv
// HUB75 panel bus as seen by a receiver.
// Protocol contract: pixel bits and row address are held stable around the
// rising edge of PCLK; a rising LATCH transfers the shifted row; OE is
// active-low. There is no back-pressure: the receiver accepts every edge.
interface hub75_receiver_if;

    logic R0, G0, B0, R1, G1, B1;
    logic RA, RB, RC, RD;
    logic PCLK, LATCH, OE;

    modport master (output R0, G0, B0, R1, G1, B1, RA, RB, RC, RD, PCLK, LATCH, OE);
    modport slave  (input  R0, G0, B0, R1, G1, B1, RA, RB, RC, RD, PCLK, LATCH, OE);

endinterface

// File: rtl/hub75_sync.sv
// Two-flop synchronizer for one bundle of asynchronous HUB75 inputs, with a
// third flop holding the previous synchronized value for rising-edge detection.
module hub75_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic [W-1:0] rise
);

    logic [W-1:0] meta_q, meta_d;
    logic [W-1:0] sync_q, sync_d;
    logic [W-1:0] prev_q, prev_d;

    // Next values: each stage takes the one before it.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Synchronizer and history registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign q    = sync_q;
    assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/hub75_receiver.sv
// HUB75 row receiver: shifts synchronized pixel data on PCLK edges and
// commits the row to a stable read port on each LATCH edge.
// Optional macro HUB75_RX_OE_CNT_EN adds a counter of OE-low cycles per row.
module hub75_receiver
    import hub75_pkg::*;
#(
    parameter int COLS  = DEF_COLS,
    parameter int CNT_W = 16
) (
    input  logic                    CLK_I,
    input  logic                    RST_I,
    hub75_receiver_if.slave         hub,
    input  logic [$clog2(COLS)-1:0] COL_SEL,
    output logic [PIX_W-1:0]        PIX_TOP,
    output logic [PIX_W-1:0]        PIX_BOT,
    output logic [ADDR_W-1:0]       ROW_ADDR,
    output logic                    ROW_VALID,
    output logic                    ROW_ERR,
    output logic [CNT_W-1:0]        ON_COUNT,
    output state_e                  dbg_state
);

    // Column counter saturates at COLS+1 so over-long rows stay distinguishable.
    localparam int CW = $clog2(COLS + 2);

    typedef logic [COLS-1:0][PIX_W-1:0] row_t;

    logic [2*PIX_W-1:0] pix_sync, pix_rise;
    logic [ADDR_W-1:0]  addr_sync, addr_rise;
    logic [2:0]         ctl_sync, ctl_rise;
    logic               pclk_rise, latch_rise, commit;
    logic               unused_sync;

    state_e            state_q, state_d;
    row_t              shift_top_q, shift_top_d, shift_bot_q, shift_bot_d;
    row_t              row_top_q, row_top_d, row_bot_q, row_bot_d;
    logic [CW-1:0]     col_cnt_q, col_cnt_d;
    logic [ADDR_W-1:0] row_addr_q, row_addr_d;
    logic              row_err_q, row_err_d;
    logic              row_valid_q, row_valid_d;

    hub75_sync #(.W(2*PIX_W)) u_sync_pix (
        .clk(CLK_I), .rst(RST_I),
        .d({hub.R0, hub.G0, hub.B0, hub.R1, hub.G1, hub.B1}),
        .q(pix_sync), .rise(pix_rise)
    );

    hub75_sync #(.W(ADDR_W)) u_sync_addr (
        .clk(CLK_I), .rst(RST_I),
        .d({hub.RD, hub.RC, hub.RB, hub.RA}),
        .q(addr_sync), .rise(addr_rise)
    );

    hub75_sync #(.W(3)) u_sync_ctl (
        .clk(CLK_I), .rst(RST_I),
        .d({hub.PCLK, hub.LATCH, hub.OE}),
        .q(ctl_sync), .rise(ctl_rise)
    );

    assign pclk_rise   = ctl_rise[2];
    assign latch_rise  = ctl_rise[1];
    assign unused_sync = ^{pix_rise, addr_rise, ctl_rise[0], ctl_sync};

    // Row state machine: LATCH wins over PCLK for the transition, COMMIT lasts one cycle.
    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE, ST_SHIFT: begin
                if (latch_rise)     state_d = ST_COMMIT;
                else if (pclk_rise) state_d = ST_SHIFT;
            end
            ST_COMMIT: begin
                commit  = 1'b1;
                state_d = pclk_rise ? ST_SHIFT : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Shift/count on PCLK; on commit snapshot the pre-shift registers so a
    // PCLK edge landing in the COMMIT cycle belongs to the next row.
    always_comb begin
        shift_top_d = shift_top_q;
        shift_bot_d = shift_bot_q;
        col_cnt_d   = col_cnt_q;
        row_top_d   = row_top_q;
        row_bot_d   = row_bot_q;
        row_addr_d  = row_addr_q;
        row_err_d   = row_err_q;
        row_valid_d = 1'b0;
        if (pclk_rise) begin
            shift_top_d = {pix_sync[2*PIX_W-1:PIX_W], shift_top_q[COLS-1:1]};
            shift_bot_d = {pix_sync[PIX_W-1:0],       shift_bot_q[COLS-1:1]};
            if (col_cnt_q != CW'(COLS + 1)) col_cnt_d = col_cnt_q + CW'(1);
        end
        if (commit) begin
            row_top_d   = shift_top_q;
            row_bot_d   = shift_bot_q;
            row_addr_d  = addr_sync;
            row_err_d   = (col_cnt_q != CW'(COLS));
            row_valid_d = 1'b1;
            col_cnt_d   = pclk_rise ? CW'(1) : '0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q     <= ST_IDLE;
            shift_top_q <= '0;
            shift_bot_q <= '0;
            col_cnt_q   <= '0;
            row_top_q   <= '0;
            row_bot_q   <= '0;
            row_addr_q  <= '0;
            row_err_q   <= 1'b0;
            row_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_top_q <= shift_top_d;
            shift_bot_q <= shift_bot_d;
            col_cnt_q   <= col_cnt_d;
            row_top_q   <= row_top_d;
            row_bot_q   <= row_bot_d;
            row_addr_q  <= row_addr_d;
            row_err_q   <= row_err_d;
            row_valid_q <= row_valid_d;
        end
    end

    // Read port over the committed row only; out-of-range columns read as 0.
    always_comb begin
        PIX_TOP = '0;
        PIX_BOT = '0;
        if (int'(COL_SEL) < COLS) begin
            PIX_TOP = row_top_q[COL_SEL];
            PIX_BOT = row_bot_q[COL_SEL];
        end
    end

    assign ROW_ADDR  = row_addr_q;
    assign ROW_ERR   = row_err_q;
    assign ROW_VALID = row_valid_q;
    assign dbg_state = state_q;

`ifdef HUB75_RX_OE_CNT_EN
    logic [CNT_W-1:0] oe_cnt_q, oe_cnt_d, on_count_q, on_count_d;
    logic             oe_low;

    assign oe_low = ~ctl_sync[0];

    // Count OE-low cycles; commit hands the interval over and restarts counting.
    always_comb begin
        oe_cnt_d   = oe_cnt_q;
        on_count_d = on_count_q;
        if (oe_low && (oe_cnt_q != '1)) oe_cnt_d = oe_cnt_q + CNT_W'(1);
        if (commit) begin
            on_count_d = oe_cnt_q;
            oe_cnt_d   = oe_low ? CNT_W'(1) : '0;
        end
    end

    // On-time counter registers.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            oe_cnt_q   <= '0;
            on_count_q <= '0;
        end else begin
            oe_cnt_q   <= oe_cnt_d;
            on_count_q <= on_count_d;
        end
    end

    assign ON_COUNT = on_count_q;
`else
    assign ON_COUNT = '0;
`endif

endmodule

// File: tb/tb_hub75_receiver.sv
// Testbench for hub75_receiver: random pixel rows against a queue-based
// model of "the last COLS pixels shifted since reset".
module tb_hub75_receiver;
    import hub75_pkg::*;

    localparam int COLS  = 32;
    localparam int CNT_W = 16;
    localparam int SW    = $clog2(COLS);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    hub75_receiver_if hub ();
    logic [SW-1:0]    col_sel = '0;
    logic [2:0]       pix_top, pix_bot;
    logic [3:0]       row_addr;
    logic             row_valid, row_err;
    logic [CNT_W-1:0] on_count;
    state_e           dbg_state;

    hub75_receiver #(.COLS(COLS), .CNT_W(CNT_W)) dut (
        .CLK_I(clk), .RST_I(rst), .hub(hub), .COL_SEL(col_sel),
        .PIX_TOP(pix_top), .PIX_BOT(pix_bot), .ROW_ADDR(row_addr),
        .ROW_VALID(row_valid), .ROW_ERR(row_err), .ON_COUNT(on_count),
        .dbg_state(dbg_state)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    logic [2:0] hist_top[$];
    logic [2:0] hist_bot[$];
    int         pend;
    logic [2:0] exp_top[COLS];
    logic [2:0] exp_bot[COLS];
    logic       exp_err;
    logic [3:0] exp_addr;
    logic [2:0] obs_top[COLS];
    logic [2:0] obs_bot[COLS];

    function automatic void model_reset();
        hist_top.delete();
        hist_bot.delete();
        pend = 0;
        for (int j = 0; j < COLS; j++) begin
            exp_top[j] = '0;
            exp_bot[j] = '0;
        end
        exp_err  = 1'b0;
        exp_addr = '0;
    endfunction

    function automatic void model_push(input logic [2:0] t, input logic [2:0] b);
        hist_top.push_back(t);
        hist_bot.push_back(b);
        if (hist_top.size() > COLS) begin
            void'(hist_top.pop_front());
            void'(hist_bot.pop_front());
        end
        pend++;
    endfunction

    // Row = most recent COLS pixels, newest at the highest column; err unless exactly COLS since last commit.
    function automatic void model_commit(input logic [3:0] addr);
        for (int j = 0; j < COLS; j++) begin
            int idx;
            idx = hist_top.size() - COLS + j;
            exp_top[j] = (idx < 0) ? 3'b000 : hist_top[idx];
            exp_bot[j] = (idx < 0) ? 3'b000 : hist_bot[idx];
        end
        exp_err  = (pend != COLS);
        exp_addr = addr;
        pend     = 0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic pulse(input logic [2:0] t, input logic [2:0] b);
        @(negedge clk);
        {hub.R0, hub.G0, hub.B0} = t;
        {hub.R1, hub.G1, hub.B1} = b;
        hub.PCLK = 1'b0;
        repeat (2) @(negedge clk);
        hub.PCLK = 1'b1;
        repeat (2) @(negedge clk);
        hub.PCLK = 1'b0;
        model_push(t, b);
    endtask

    task automatic random_pulses(input int n);
        for (int i = 0; i < n; i++) pulse(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    endtask

    // mode 0: LATCH only; 1: PCLK and LATCH rise together; 2: PCLK rises one cycle after LATCH.
    task automatic do_latch(input logic [3:0] addr, input int mode, input logic [2:0] t,
                            input logic [2:0] b, output int lat, output int nv);
        @(negedge clk);
        {hub.RD, hub.RC, hub.RB, hub.RA} = addr;
        {hub.R0, hub.G0, hub.B0} = t;
        {hub.R1, hub.G1, hub.B1} = b;
        hub.PCLK = 1'b0;
        if (mode != 0) repeat (2) @(negedge clk);
        hub.LATCH = 1'b1;
        if (mode == 1) begin
            hub.PCLK = 1'b1;
            model_push(t, b);
        end
        model_commit(addr);
        if (mode == 2) model_push(t, b);
        lat = -1;
        nv  = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (row_valid === 1'b1) begin
                nv++;
                if (lat < 0) lat = i;
            end
            if (mode == 2 && i == 1) hub.PCLK = 1'b1;
            if (i == 2) begin
                hub.LATCH = 1'b0;
                if (mode == 1) hub.PCLK = 1'b0;
            end
            if (mode == 2 && i == 3) hub.PCLK = 1'b0;
        end
    endtask

    task automatic readout();
        for (int j = 0; j < COLS; j++) begin
            @(negedge clk);
            col_sel = SW'(j);
            #1;
            obs_top[j] = pix_top;
            obs_bot[j] = pix_bot;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (row_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", row_valid); end
        total++; if (row_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", row_err); end
        total++; if (row_addr !== 4'd0) begin bad++; $display("FAIL rst_addr got=%0d exp=0", row_addr); end
        total++; if (on_count !== '0) begin bad++; $display("FAIL rst_on_count got=%0d exp=0", on_count); end
        total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL rst_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
        rst = 1'b0;
        model_reset();
        readout();
        for (int j = 0; j < COLS; j++) begin
            total++;
            if (obs_top[j] !== 3'b000 || obs_bot[j] !== 3'b000) begin
                bad++; $display("FAIL rst_pix col=%0d got=%b/%b exp=000/000", j, obs_top[j], obs_bot[j]);
            end
        end
    endtask

    task automatic test_basic_row();
        int lat, nv;
        for (int n = 0; n < COLS; n++) pulse(3'(n), ~3'(n));
        do_latch(4'd5, 0, 3'd0, 3'd0, lat, nv);
        total++; if (nv !== 1) begin bad++; $display("FAIL basic_valid_pulses got=%0d exp=1", nv); end
        total++; if (lat !== 4) begin bad++; $display("FAIL basic_latency got=%0d exp=4", lat); end
        total++; if (row_addr !== 4'd5) begin bad++; $display("FAIL basic_addr got=%0d exp=5", row_addr); end
        total++; if (row_err !== 1'b0) begin bad++; $display("FAIL basic_err got=%b exp=0", row_err); end
        readout();
        total++; if (obs_top[9] !== 3'b001) begin bad++; $display("FAIL basic_col9 got=%b exp=001", obs_top[9]); end
        for (int j = 0; j < COLS; j++) begin
            total++;
            if (obs_top[j] !== exp_top[j] || obs_bot[j] !== exp_bot[j]) begin
                bad++; $display("FAIL basic_pix col=%0d got=%b/%b exp=%b/%b", j, obs_top[j], obs_bot[j], exp_top[j], exp_bot[j]);
            end
        end
    endtask

    task automatic test_count_err();
        int lat, nv;
        int lens[4] = '{31, 40, 0, 32};
        for (int k = 0; k < 4; k++) begin
            random_pulses(lens[k]);
            do_latch(4'(k + 1), 0, 3'd0, 3'd0, lat, nv);
            total++; if (nv !== 1) begin bad++; $display("FAIL cnt_valid len=%0d got=%0d exp=1", lens[k], nv); end
            total++; if (row_err !== exp_err) begin bad++; $display("FAIL cnt_err len=%0d got=%b exp=%b", lens[k], row_err, exp_err); end
            total++; if (row_addr !== exp_addr) begin bad++; $display("FAIL cnt_addr len=%0d got=%0d exp=%0d", lens[k], row_addr, exp_addr); end
            readout();
            for (int j = 0; j < COLS; j++) begin
                total++;
                if (obs_top[j] !== exp_top[j] || obs_bot[j] !== exp_bot[j]) begin
                    bad++; $display("FAIL cnt_pix len=%0d col=%0d got=%b/%b exp=%b/%b", lens[k], j, obs_top[j], obs_bot[j], exp_top[j], exp_bot[j]);
                end
            end
        end
    endtask

    task automatic test_same_cycle();
        int lat, nv;
        logic [2:0] t, b;
        random_pulses(COLS - 1);
        t = 3'($urandom_range(1, 7));
        b = 3'($urandom_range(0, 7));
        do_latch(4'd6, 1, t, b, lat, nv);
        total++; if (lat !== 4) begin bad++; $display("FAIL same_latency got=%0d exp=4", lat); end
        total++; if (row_err !== 1'b0) begin bad++; $display("FAIL same_err got=%b exp=0", row_err); end
        readout();
        total++; if (obs_top[COLS-1] !== t) begin bad++; $display("FAIL same_last_col got=%b exp=%b", obs_top[COLS-1], t); end
        for (int j = 0; j < COLS; j++) begin
            total++;
            if (obs_top[j] !== exp_top[j] || obs_bot[j] !== exp_bot[j]) begin
                bad++; $display("FAIL same_pix col=%0d got=%b/%b exp=%b/%b", j, obs_top[j], obs_bot[j], exp_top[j], exp_bot[j]);
            end
        end
    endtask

    task automatic test_pclk_in_commit();
        int lat, nv;
        logic [2:0] t, b;
        random_pulses(COLS);
        t = 3'($urandom_range(0, 7));
        b = 3'($urandom_range(0, 7));
        do_latch(4'd7, 2, t, b, lat, nv);
        total++; if (row_err !== 1'b0) begin bad++; $display("FAIL commit_pclk_err1 got=%b exp=0", row_err); end
        random_pulses(COLS - 1);
        do_latch(4'd8, 0, 3'd0, 3'd0, lat, nv);
        total++; if (row_err !== 1'b0) begin bad++; $display("FAIL commit_pclk_err2 got=%b exp=0", row_err); end
        readout();
        total++; if (obs_top[0] !== t || obs_bot[0] !== b) begin bad++; $display("FAIL commit_pclk_col0 got=%b/%b exp=%b/%b", obs_top[0], obs_bot[0], t, b); end
        for (int j = 0; j < COLS; j++) begin
            total++;
            if (obs_top[j] !== exp_top[j] || obs_bot[j] !== exp_bot[j]) begin
                bad++; $display("FAIL commit_pclk_pix col=%0d got=%b/%b exp=%b/%b", j, obs_top[j], obs_bot[j], exp_top[j], exp_bot[j]);
            end
        end
    endtask

    task automatic test_mid_reset();
        int lat, nv;
        random_pulses(16);
        do_reset();
        @(negedge clk);
        total++; if (row_err !== 1'b0 || row_addr !== 4'd0) begin bad++; $display("FAIL midrst_clear got=%b/%0d exp=0/0", row_err, row_addr); end
        random_pulses(COLS);
        do_latch(4'd9, 0, 3'd0, 3'd0, lat, nv);
        total++; if (row_err !== 1'b0) begin bad++; $display("FAIL midrst_err got=%b exp=0", row_err); end
        total++; if (row_addr !== 4'd9) begin bad++; $display("FAIL midrst_addr got=%0d exp=9", row_addr); end
        readout();
        for (int j = 0; j < COLS; j++) begin
            total++;
            if (obs_top[j] !== exp_top[j] || obs_bot[j] !== exp_bot[j]) begin
                bad++; $display("FAIL midrst_pix col=%0d got=%b/%b exp=%b/%b", j, obs_top[j], obs_bot[j], exp_top[j], exp_bot[j]);
            end
        end
    endtask

    task automatic test_on_count();
        int lat, nv;
        logic [CNT_W-1:0] exp_on;
`ifdef HUB75_RX_OE_CNT_EN
        exp_on = CNT_W'(100);
`else
        exp_on = '0;
`endif
        do_latch(4'd10, 0, 3'd0, 3'd0, lat, nv);
        @(negedge clk);
        hub.OE = 1'b0;
        repeat (100) @(negedge clk);
        hub.OE = 1'b1;
        repeat (4) @(negedge clk);
        do_latch(4'd11, 0, 3'd0, 3'd0, lat, nv);
        total++; if (nv !== 1) begin bad++; $display("FAIL oe_valid got=%0d exp=1", nv); end
        total++; if (on_count !== exp_on) begin bad++; $display("FAIL oe_on_count got=%0d exp=%0d", on_count, exp_on); end
    endtask

    task automatic test_back_to_back();
        int lat, nv;
        for (int r = 0; r < 16; r++) begin
            random_pulses(COLS);
            do_latch(4'(r), 0, 3'd0, 3'd0, lat, nv);
            total++; if (nv !== 1) begin bad++; $display("FAIL b2b_valid row=%0d got=%0d exp=1", r, nv); end
            total++; if (row_addr !== 4'(r)) begin bad++; $display("FAIL b2b_addr got=%0d exp=%0d", row_addr, r); end
            total++; if (row_err !== 1'b0) begin bad++; $display("FAIL b2b_err row=%0d got=%b exp=0", r, row_err); end
            readout();
            for (int j = 0; j < COLS; j++) begin
                total++;
                if (obs_top[j] !== exp_top[j] || obs_bot[j] !== exp_bot[j]) begin
                    bad++; $display("FAIL b2b_pix row=%0d col=%0d got=%b/%b exp=%b/%b", r, j, obs_top[j], obs_bot[j], exp_top[j], exp_bot[j]);
                end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        {hub.R0, hub.G0, hub.B0, hub.R1, hub.G1, hub.B1} = '0;
        {hub.RA, hub.RB, hub.RC, hub.RD} = '0;
        hub.PCLK  = 1'b0;
        hub.LATCH = 1'b0;
        hub.OE    = 1'b1;
        test_reset();
        test_basic_row();
        test_count_err();
        test_same_cycle();
        test_pclk_in_commit();
        test_mid_reset();
        test_on_count();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
